// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding on
// the instruction bus and buffers returned words in a small FIFO for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;

    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic          drop;
    logic          halt;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic          fifo_adel  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_post_pop, count_nxt;

    logic          aligned, pop, push, fetch_ok, issue, adel_push, resp, resp_push;
    logic [31:0]   push_instr, push_pc;
    logic          push_adel;

    // Request address lives in its own register so a redirect can retarget pc
    // while the bus still sees the old, not-yet-accepted address.
    always_comb begin
        aligned        = (pc[1:0] == 2'b00);
        pop            = out_valid && out_ready && !redirect_valid;
        count_post_pop = count - CW'(pop);
        fetch_ok       = (state == IDLE) && !halt && !redirect_valid && (count_post_pop < FULL);
        issue          = fetch_ok && aligned;
        adel_push      = fetch_ok && !aligned;
        resp           = (state == DATA) && iresp_data_ok;
        resp_push      = resp && !drop && !redirect_valid;
        push           = resp_push || adel_push;
        count_nxt      = count_post_pop + CW'(push);
        push_instr     = adel_push ? '0 : iresp_data;
        push_pc        = adel_push ? pc : req_addr;
        push_adel      = adel_push;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ireq_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (iresp_data_ok) begin
                    // Redirect or misaligned target goes through IDLE so the next
                    // request is formed from the updated pc.
                    if (redirect_valid || !aligned || (count_nxt >= FULL)) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ireq_valid  = (state == ADDR);
        ireq_addr   = req_addr;
        out_valid   = (count != '0);
        out_instr   = out_valid ? fifo_instr[rd_ptr] : '0;
        out_pc      = out_valid ? fifo_pc[rd_ptr] : '0;
        out_pcplus4 = out_valid ? fifo_pc[rd_ptr] + 32'd4 : '0;
        out_adel    = out_valid ? fifo_adel[rd_ptr] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            req_addr <= '0;
            drop     <= 1'b0;
            halt     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if ((state == ADDR) && ireq_addr_ok && !drop) begin
                pc <= pc + 32'd4;
            end

            if (issue || ((state == DATA) && (state_nxt == ADDR))) begin
                req_addr <= pc;
            end

            if (redirect_valid && ((state == ADDR) || ((state == DATA) && !iresp_data_ok))) begin
                drop <= 1'b1;
            end else if (resp) begin
                drop <= 1'b0;
            end

            if (redirect_valid) begin
                halt <= 1'b0;
            end else if (adel_push) begin
                halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            fifo_instr[wr_ptr] <= push_instr;
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_adel[wr_ptr]  <= push_adel;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: randomized-latency bus responder plus a
// stream-level model (expected entries are consecutive words from the last redirect).
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'h1357_9bdf;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_adel;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_adel(out_adel)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int addr_lo = 0, addr_hi = 0, data_lo = 0, data_hi = 0, hold_addr = 0;
    bit force_data_ok = 0;
    bit rsp_pending = 0, wait_set = 0, prev_req = 0;
    int rsp_wait = 0, addr_wait = 0, bus_viol = 0;
    logic [31:0] rsp_addr = '0, prev_addr = '0;

    logic [31:0] reqs[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic [31:0] pop_p4[$];
    logic        pop_adel[$];
    int          pop_cyc[$];

    // Reference: a word at an aligned address reads as addr^KEY; misaligned yields 0.
    function automatic logic [31:0] model_instr(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 32'h0 : (a ^ KEY);
    endfunction

    task automatic clear_log();
        reqs.delete(); pop_pc.delete(); pop_instr.delete();
        pop_p4.delete(); pop_adel.delete(); pop_cyc.delete();
    endtask

    // One clock: bus responder drives at negedge, pops logged, sample #1 after posedge.
    task automatic tick();
        bit busy;
        @(negedge clk);
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b0;
        if (!resetn) begin
            rsp_pending = 0; wait_set = 0; prev_req = 0;
        end else begin
            busy = rsp_pending;
            if (force_data_ok) begin
                iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef; force_data_ok = 0;
            end else if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    iresp_data_ok = 1'b1; iresp_data = rsp_addr ^ KEY; rsp_pending = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (ireq_valid) begin
                if (busy || (prev_req && ireq_addr !== prev_addr)) bus_viol++;
                if (!wait_set) begin
                    addr_wait = (hold_addr > 0) ? hold_addr : int'($urandom_range(addr_hi, addr_lo));
                    hold_addr = 0; wait_set = 1;
                end
                if (addr_wait == 0) begin
                    ireq_addr_ok = 1'b1; rsp_pending = 1; rsp_addr = ireq_addr;
                    rsp_wait = int'($urandom_range(data_hi, data_lo)); wait_set = 0;
                    reqs.push_back(ireq_addr);
                end else begin
                    addr_wait--;
                end
            end else if (prev_req) begin
                bus_viol++;
            end
            prev_req  = ireq_valid && !ireq_addr_ok;
            prev_addr = ireq_addr;
        end
        if (resetn && out_valid && out_ready && !redirect_valid) begin
            pop_pc.push_back(out_pc); pop_instr.push_back(out_instr);
            pop_p4.push_back(out_pcplus4); pop_adel.push_back(out_adel);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        clear_log();
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_enter_data(input string name);
        int n = 0;
        while (rsp_pending && n < 50) begin tick(); n++; end
        while (!rsp_pending && n < 100) begin tick(); n++; end
        checks++;
        if (!rsp_pending) begin
            errors++; $display("FAIL %s_reach_data: rsp_pending=%0d, required 1 within 100 cycles", name, rsp_pending);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
        tick(); tick();
        checks++;
        if (ireq_valid !== 1'b0 || ireq_addr !== 32'h0) begin
            errors++; $display("FAIL reset_bus: ireq_valid=%b ireq_addr=%h, required 0/00000000", ireq_valid, ireq_addr);
        end
        checks++;
        if (out_valid !== 1'b0 || out_adel !== 1'b0) begin
            errors++; $display("FAIL reset_valid: out_valid=%b out_adel=%b, required 0/0", out_valid, out_adel);
        end
        checks++;
        if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pcplus4 !== 32'h0) begin
            errors++; $display("FAIL reset_data: instr=%h pc=%h pcplus4=%h, required all 0", out_instr, out_pc, out_pcplus4);
        end
        redirect_valid = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_stream();
        clear_log();
        addr_lo = 0; addr_hi = 0; data_lo = 0; data_hi = 0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (reqs.size() == 0 || reqs[0] !== RESET_PC) begin
            errors++; $display("FAIL t1_first_addr: %0d requests, first=%h, required %h", reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hx, RESET_PC);
        end
        checks++;
        if (pop_pc.size() < 8) begin
            errors++; $display("FAIL t1_count: %0d entries, required >= 8", pop_pc.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            logic [31:0] e;
            e = RESET_PC + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== e || pop_instr[i] !== model_instr(e) || pop_p4[i] !== e + 32'd4 || pop_adel[i] !== 1'b0) begin
                errors++; $display("FAIL t1_entry[%0d]: pc=%h instr=%h p4=%h adel=%b, required %h %h %h 0", i, pop_pc[i], pop_instr[i], pop_p4[i], pop_adel[i], e, model_instr(e), e + 32'd4);
            end
        end
        for (int i = 1; i < pop_cyc.size(); i++) begin
            checks++;
            if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
                errors++; $display("FAIL t1_rate[%0d]: spacing %0d cycles, required 2", i, pop_cyc[i] - pop_cyc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_new = 0;
        int late_req = 0;
        out_ready = 1'b0; addr_lo = 0; addr_hi = 2; data_lo = 0; data_hi = 2;
        do_redirect(32'h0000_4000);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 30 && ireq_valid) late_req++;
        end
        foreach (reqs[i]) if (reqs[i] - 32'h0000_4000 < 32'h1000) n_new++;
        checks++;
        if (n_new != DEPTH) begin
            errors++; $display("FAIL t2_buffered: %0d requests while stalled, required %0d", n_new, DEPTH);
        end
        checks++;
        if (late_req != 0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL t2_stalled: ireq_valid seen %0d times, out_valid=%b, required 0 and 1", late_req, out_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (ireq_valid !== 1'b1) begin
            errors++; $display("FAIL t2_issue_on_pop: ireq_valid=%b after pop from full, required 1", ireq_valid);
        end
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (pop_pc.size() <= DEPTH) begin
            errors++; $display("FAIL t2_resume: %0d entries after release, required > %0d", pop_pc.size(), DEPTH);
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h0000_4000 + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== e || pop_instr[i] !== model_instr(e) || pop_p4[i] !== e + 32'd4) begin
                errors++; $display("FAIL t2_entry[%0d]: pc=%h instr=%h p4=%h, required %h %h %h", i, pop_pc[i], pop_instr[i], pop_p4[i], e, model_instr(e), e + 32'd4);
            end
        end
    endtask

    task automatic test_redirect_data();
        out_ready = 1'b1; addr_lo = 0; addr_hi = 1; data_lo = 3; data_hi = 3;
        wait_enter_data("t3");
        do_redirect(32'h8000_1000);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t3_flush: out_valid=%b after redirect, required 0", out_valid);
        end
        data_lo = 0; data_hi = 2;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (pop_pc.size() < 3) begin
            errors++; $display("FAIL t3_count: %0d entries, required >= 3", pop_pc.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h8000_1000 + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== e || pop_instr[i] !== model_instr(e)) begin
                errors++; $display("FAIL t3_entry[%0d]: pc=%h instr=%h, required %h %h", i, pop_pc[i], pop_instr[i], e, model_instr(e));
            end
        end
    endtask

    task automatic test_redirect_edges();
        logic [31:0] a;
        int n;
        out_ready = 1'b1; addr_lo = 0; addr_hi = 0; data_lo = 0; data_hi = 0;
        // redirect lands in the same cycle as the response
        wait_enter_data("t4a");
        do_redirect(32'h0000_2000);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t4a_flush: out_valid=%b, required 0", out_valid);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== 32'h0000_2000 || pop_pc[pop_pc.size()-1] !== 32'h0000_2000 + 32'(4 * (pop_pc.size() - 1))) begin
            errors++; $display("FAIL t4a_stream: %0d entries, first=%h, required >= 3 from 00002000", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx);
        end
        // redirect while the bus holds off addr_ok for 4 cycles
        wait_enter_data("t4b");
        hold_addr = 4;
        n = 0;
        while (!ireq_valid && n < 20) begin tick(); n++; end
        a = ireq_addr;
        do_redirect(32'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ireq_valid !== 1'b1 || ireq_addr !== a) begin
                errors++; $display("FAIL t4b_hold[%0d]: ireq_valid=%b addr=%h, required 1 %h", i, ireq_valid, ireq_addr, a);
            end
            tick();
        end
        checks++;
        if (reqs.size() == 0 || reqs[0] !== a) begin
            errors++; $display("FAIL t4b_accept: accepted %h, required %h", (reqs.size() > 0) ? reqs[0] : 32'hx, a);
        end
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < pop_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h0000_3000 + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== e || pop_instr[i] !== model_instr(e)) begin
                errors++; $display("FAIL t4b_entry[%0d]: pc=%h instr=%h, required %h %h", i, pop_pc[i], pop_instr[i], e, model_instr(e));
            end
        end
        checks++;
        if (pop_pc.size() < 3) begin
            errors++; $display("FAIL t4b_count: %0d entries, required >= 3", pop_pc.size());
        end
    endtask

    task automatic test_misaligned();
        int n_req = 0;
        out_ready = 1'b1; addr_lo = 0; addr_hi = 1; data_lo = 0; data_hi = 2;
        do_redirect(32'h0000_0102);
        for (int i = 0; i < 25; i++) tick();
        foreach (reqs[i]) if (reqs[i] - 32'h0000_0100 < 32'h100) n_req++;
        checks++;
        if (n_req != 0 || ireq_valid !== 1'b0) begin
            errors++; $display("FAIL t5_no_req: %0d requests near target, ireq_valid=%b, required 0/0", n_req, ireq_valid);
        end
        checks++;
        if (pop_pc.size() != 1) begin
            errors++; $display("FAIL t5_count: %0d entries, required 1", pop_pc.size());
        end else if (pop_pc[0] !== 32'h0000_0102 || pop_instr[0] !== 32'h0 || pop_p4[0] !== 32'h0000_0106 || pop_adel[0] !== 1'b1) begin
            errors++; $display("FAIL t5_entry: pc=%h instr=%h p4=%h adel=%b, required 00000102 00000000 00000106 1", pop_pc[0], pop_instr[0], pop_p4[0], pop_adel[0]);
        end
        do_redirect(32'h0000_0100);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (pop_pc.size() < 3) begin
            errors++; $display("FAIL t5_resume: %0d entries, required >= 3", pop_pc.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            logic [31:0] e;
            e = 32'h0000_0100 + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== e || pop_instr[i] !== model_instr(e) || pop_adel[i] !== 1'b0) begin
                errors++; $display("FAIL t5_entry[%0d]: pc=%h instr=%h adel=%b, required %h %h 0", i, pop_pc[i], pop_instr[i], pop_adel[i], e, model_instr(e));
            end
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; addr_lo = 0; addr_hi = 0; data_lo = 0; data_hi = 0;
        do_redirect(32'hffff_fff8);
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (pop_pc.size() < 3) begin
            errors++; $display("FAIL wrap_count: %0d entries, required >= 3", pop_pc.size());
        end else if (pop_pc[1] !== 32'hffff_fffc || pop_p4[1] !== 32'h0 || pop_pc[2] !== 32'h0) begin
            errors++; $display("FAIL wrap_boundary: pc1=%h p4_1=%h pc2=%h, required fffffffc 00000000 00000000", pop_pc[1], pop_p4[1], pop_pc[2]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; addr_lo = 0; addr_hi = 0; data_lo = 5; data_hi = 5;
        wait_enter_data("t6");
        resetn = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin
            errors++; $display("FAIL t6_reset: out_valid=%b ireq_valid=%b, required 0/0", out_valid, ireq_valid);
        end
        resetn = 1'b1; data_lo = 0; data_hi = 0; force_data_ok = 1;
        clear_log();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t6_stray: out_valid=%b after stray data_ok, required 0", out_valid);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (reqs.size() == 0 || reqs[0] !== RESET_PC) begin
            errors++; $display("FAIL t6_first_addr: first=%h, required %h", (reqs.size() > 0) ? reqs[0] : 32'hx, RESET_PC);
        end
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== RESET_PC || pop_instr[0] !== model_instr(RESET_PC)) begin
            errors++; $display("FAIL t6_stream: %0d entries first pc=%h, required >= 3 from %h", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_bus_protocol();
        checks++;
        if (bus_viol != 0) begin
            errors++; $display("FAIL bus_protocol: %0d violations (addr change, withdrawn or overlapping request), required 0", bus_viol);
        end
    endtask

    initial begin
        resetn = 1'b0; ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_data();
        test_redirect_edges();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_bus_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
